// File: rtl/axi_lite_initiator_pkg.sv
// Shared types and constants for the native-port to AXI4-Lite initiator bridge.
package axi_lite_initiator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RRESP,
    WRITE,
    WRESP,
    DONE
  } state_t;

  localparam logic [2:0]  PROT_DATA     = 3'b000;
  localparam logic [2:0]  PROT_INSN     = 3'b100;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_lite_initiator_wdog.sv
// Response watchdog: cleared by load, advances while count is high, and flags
// expiry on the cycle it sits at TIMEOUT_CYCLES-1 while still counting.
module axi_lite_initiator_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && (cnt != LAST)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = count && (cnt == LAST);

endmodule

// File: rtl/axi_lite_initiator.sv
// Native valid/ready memory port to AXI4-Lite master, one transaction in flight.
// Optional response timeout enabled by defining AXI_LITE_INITIATOR_TIMEOUT_EN.
module axi_lite_initiator
  import axi_lite_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  output logic        bus_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      state, state_nxt;
  logic        mem_ready_nxt;
  logic [31:0] mem_rdata_nxt;
  logic        awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [31:0] awaddr_nxt, wdata_nxt, araddr_nxt;
  logic [3:0]  wstrb_nxt;
  logic [2:0]  awprot_nxt, arprot_nxt;

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
  logic expired;
  logic bus_err_nxt;

  axi_lite_initiator_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .load   (state == IDLE),
    .count  ((state == READ) || (state == RRESP) || (state == WRITE) || (state == WRESP)),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= bus_err_nxt;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_nxt     = state;
    mem_ready_nxt = 1'b0;
    mem_rdata_nxt = mem_rdata;
    awvalid_nxt   = mem_axi_awvalid;
    wvalid_nxt    = mem_axi_wvalid;
    bready_nxt    = mem_axi_bready;
    arvalid_nxt   = mem_axi_arvalid;
    rready_nxt    = mem_axi_rready;
    awaddr_nxt    = mem_axi_awaddr;
    awprot_nxt    = mem_axi_awprot;
    wdata_nxt     = mem_axi_wdata;
    wstrb_nxt     = mem_axi_wstrb;
    araddr_nxt    = mem_axi_araddr;
    arprot_nxt    = mem_axi_arprot;
`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
    bus_err_nxt   = bus_err;
`endif

    case (state)
      IDLE: begin
        // Request fields go straight into the AXI output registers, which
        // then stay frozen until the matching handshake.
        if (mem_valid) begin
          if (mem_wstrb != 4'b0000) begin
            awaddr_nxt  = mem_addr;
            awprot_nxt  = PROT_DATA;
            wdata_nxt   = mem_wdata;
            wstrb_nxt   = mem_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WRITE;
          end else begin
            araddr_nxt  = mem_addr;
            arprot_nxt  = mem_instr ? PROT_INSN : PROT_DATA;
            arvalid_nxt = 1'b1;
            state_nxt   = READ;
          end
        end
      end
      READ: begin
        if (mem_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RRESP;
        end
      end
      RRESP: begin
        if (mem_axi_rvalid) begin
          mem_rdata_nxt = mem_axi_rdata;
          rready_nxt    = 1'b0;
          mem_ready_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      WRITE: begin
        // AW and W retire independently; B is awaited once both are gone.
        if (mem_axi_awready) awvalid_nxt = 1'b0;
        if (mem_axi_wready) wvalid_nxt = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WRESP;
        end
      end
      WRESP: begin
        if (mem_axi_bvalid) begin
          bready_nxt    = 1'b0;
          mem_ready_nxt = 1'b1;
          state_nxt     = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

`ifdef AXI_LITE_INITIATOR_TIMEOUT_EN
    // A genuine completion on the expiry cycle takes precedence.
    if (expired && (state_nxt != DONE)) begin
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      bready_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rready_nxt    = 1'b0;
      bus_err_nxt   = 1'b1;
      mem_ready_nxt = 1'b1;
      state_nxt     = DONE;
      if ((state == READ) || (state == RRESP)) mem_rdata_nxt = TIMEOUT_RDATA;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      mem_ready       <= 1'b0;
      mem_rdata       <= '0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_axi_awaddr  <= '0;
      mem_axi_awprot  <= '0;
      mem_axi_wdata   <= '0;
      mem_axi_wstrb   <= '0;
      mem_axi_araddr  <= '0;
      mem_axi_arprot  <= '0;
    end else begin
      state           <= state_nxt;
      mem_ready       <= mem_ready_nxt;
      mem_rdata       <= mem_rdata_nxt;
      mem_axi_awvalid <= awvalid_nxt;
      mem_axi_wvalid  <= wvalid_nxt;
      mem_axi_bready  <= bready_nxt;
      mem_axi_arvalid <= arvalid_nxt;
      mem_axi_rready  <= rready_nxt;
      mem_axi_awaddr  <= awaddr_nxt;
      mem_axi_awprot  <= awprot_nxt;
      mem_axi_wdata   <= wdata_nxt;
      mem_axi_wstrb   <= wstrb_nxt;
      mem_axi_araddr  <= araddr_nxt;
      mem_axi_arprot  <= arprot_nxt;
    end
  end

endmodule
